// File: rtl/audio_spi_tgt_pkg.sv
// Shared constants, FSM encoding and frame-field helpers for the audio SPI register target.
package audio_spi_tgt_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 8;
  localparam int CNT_W      = 5;

  // Bit-counter values: frame complete, last bit arriving, R/W bit arriving
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_RW   = CNT_W'(FRAME_BITS - 1 - RW_BIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RDOUT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_BITS-1:0] f);
    return f[FRAME_BITS-1 -: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_BITS-1:0] f);
    return f[DATA_W-1:0];
  endfunction

  function automatic logic frame_is_read(input logic [FRAME_BITS-1:0] f);
    return f[RW_BIT];
  endfunction

endpackage

// File: rtl/audio_spi_tgt_if.sv
// Pin/bus bundle of the audio SPI target: SPI pins, write notification, host read port, status.
interface audio_spi_tgt_if;
  import audio_spi_tgt_pkg::*;

  logic              iSCLK;
  logic              iCS_n;
  logic              iDIN;
  logic              oDOUT;
  logic              oDOUT_OE;
  logic              oWR_STB;
  logic [ADDR_W-1:0] oWR_ADDR;
  logic [DATA_W-1:0] oWR_DATA;
  logic [ADDR_W-1:0] iHOST_ADDR;
  logic [DATA_W-1:0] oHOST_DATA;
  logic [7:0]        oFRAME_CNT;
  logic              oERR;

  modport slave (
    input  iSCLK, iCS_n, iDIN, iHOST_ADDR,
    output oDOUT, oDOUT_OE, oWR_STB, oWR_ADDR, oWR_DATA, oHOST_DATA, oFRAME_CNT, oERR
  );

  modport master (
    output iSCLK, iCS_n, iDIN, iHOST_ADDR,
    input  oDOUT, oDOUT_OE, oWR_STB, oWR_ADDR, oWR_DATA, oHOST_DATA, oFRAME_CNT, oERR
  );

endinterface

// File: rtl/audio_spi_tgt_sync.sv
// Multi-flop synchronizer with rise/fall detection for one asynchronous input.
// Edges are suppressed until the chain has been refilled after reset, so a pin already away from its idle level produces no false edge.
module audio_spi_tgt_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   chain_s;
  logic [STAGES:0]   vld_q;
  logic              prev_q;

  assign chain_s = {sync_q, d_i};

  // synchronizer chain, edge history and post-reset priming flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= chain_s[STAGES-1:0];
      prev_q <= sync_q[STAGES-1];
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/audio_spi_tgt.sv
// SPI register target for audio codec control: 16-bit MSB-first frames (7-bit address, R/W, 8-bit data).
// Readback on oDOUT is built only when AUDIO_SPI_TGT_READ_EN is defined; otherwise read frames are no-ops.
module audio_spi_tgt
  import audio_spi_tgt_pkg::*;
#(
  parameter int REG_NUM     = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic           iCLK_50,
  input  logic           iRESET_n,
  audio_spi_tgt_if.slave bus
);

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic cs_n_s, cs_rise_s, cs_fall_s;
  logic din_s, din_rise_s, din_fall_s;
  logic unused_sync_s;

  audio_spi_tgt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk_i (iCLK_50), .rst_ni(iRESET_n), .d_i(bus.iSCLK),
    .q_o   (sclk_s),  .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  audio_spi_tgt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i (iCLK_50), .rst_ni(iRESET_n), .d_i(bus.iCS_n),
    .q_o   (cs_n_s),  .rise_o(cs_rise_s), .fall_o(cs_fall_s)
  );

  audio_spi_tgt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_din (
    .clk_i (iCLK_50), .rst_ni(iRESET_n), .d_i(bus.iDIN),
    .q_o   (din_s),   .rise_o(din_rise_s), .fall_o(din_fall_s)
  );

  assign unused_sync_s = ^{sclk_s, cs_n_s, din_rise_s, din_fall_s};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [FRAME_BITS-1:0] rx_q, rx_nxt_s;
  logic                  sample_s, last_bit_s, wr_en_s;
  logic                  wr_stb_q, err_q, dout_q, dout_oe_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q, host_data_q;
  logic [7:0]            frame_cnt_q;
  logic [DATA_W-1:0]     regs_q [REG_NUM];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < REG_NUM);
  endfunction

  // Unimplemented addresses read as zero
  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (addr_ok(a)) v = regs_q[a];
    else            v = '0;
    return v;
  endfunction

  assign sample_s   = sclk_rise_s && ((state_q == ST_SHIFT) || (state_q == ST_RDOUT))
                      && (cnt_q != CNT_FULL);
  assign last_bit_s = sample_s && (cnt_q == CNT_LAST);
  assign rx_nxt_s   = {rx_q[FRAME_BITS-2:0], din_s};
  assign wr_en_s    = last_bit_s && !frame_is_read(rx_nxt_s) && addr_ok(frame_addr(rx_nxt_s));

`ifdef AUDIO_SPI_TGT_READ_EN
  logic rw_bit_s;
  assign rw_bit_s = sample_s && (cnt_q == CNT_RW) && din_s;
`endif

  // FSM state register
  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next state; CS rise abandons whatever frame is in progress
  always_comb begin
    state_d = state_q;
    if (cs_rise_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) state_d = ST_SHIFT;
          else           state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (last_bit_s) begin
            state_d = ST_DONE;
          end
`ifdef AUDIO_SPI_TGT_READ_EN
          else if (rw_bit_s) begin
            state_d = ST_RDOUT;
          end
`endif
          else begin
            state_d = ST_SHIFT;
          end
        end
        ST_RDOUT: begin
          if (last_bit_s) state_d = ST_DONE;
          else            state_d = ST_RDOUT;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // bit counter, shift-in register, write notification and frame status
  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      cnt_q       <= '0;
      rx_q        <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_cnt_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      err_q    <= 1'b0;
      if (cs_rise_s) begin
        cnt_q <= '0;
        if (cnt_q == CNT_FULL)   frame_cnt_q <= frame_cnt_q + 8'd1;
        else if (cnt_q != 5'd0) err_q <= 1'b1;
      end else if (cs_fall_s) begin
        cnt_q <= '0;
        rx_q  <= '0;
      end else if (sample_s) begin
        cnt_q <= cnt_q + 5'd1;
        rx_q  <= rx_nxt_s;
        if (wr_en_s) begin
          wr_stb_q  <= 1'b1;
          wr_addr_q <= frame_addr(rx_nxt_s);
          wr_data_q <= frame_data(rx_nxt_s);
        end
      end
    end
  end

  // register file and host read port; a same-edge SPI write is seen by the host one cycle later
  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      host_data_q <= '0;
    end else begin
      if (wr_en_s) regs_q[frame_addr(rx_nxt_s)] <= frame_data(rx_nxt_s);
      host_data_q <= rd_reg(bus.iHOST_ADDR);
    end
  end

`ifdef AUDIO_SPI_TGT_READ_EN
  logic [DATA_W-1:0] tx_q;

  // readback shifter: loaded when the R/W bit arrives, one bit out per SCLK fall in RDOUT
  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      tx_q      <= '0;
      dout_q    <= 1'b1;
      dout_oe_q <= 1'b0;
    end else if (cs_rise_s) begin
      tx_q      <= '0;
      dout_q    <= 1'b1;
      dout_oe_q <= 1'b0;
    end else if (rw_bit_s && (state_q == ST_SHIFT)) begin
      tx_q <= rd_reg(rx_q[ADDR_W-1:0]);
    end else if (sclk_fall_s && (state_q == ST_RDOUT)) begin
      dout_q    <= tx_q[DATA_W-1];
      tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
      dout_oe_q <= 1'b1;
    end
  end
`else
  // no readback: data pin idles high and is never enabled
  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      dout_q    <= 1'b1;
      dout_oe_q <= 1'b0;
    end else begin
      dout_q    <= 1'b1;
      dout_oe_q <= 1'b0;
    end
  end
`endif

  assign bus.oDOUT      = dout_q;
  assign bus.oDOUT_OE   = dout_oe_q;
  assign bus.oWR_STB    = wr_stb_q;
  assign bus.oWR_ADDR   = wr_addr_q;
  assign bus.oWR_DATA   = wr_data_q;
  assign bus.oHOST_DATA = host_data_q;
  assign bus.oFRAME_CNT = frame_cnt_q;
  assign bus.oERR       = err_q;

endmodule
